spram_lanes_clr: RTL and testbench

Parametrised single-port RAM with lane (sub-word) write enables, a valid/ready request handshake, and a hardware clear sequencer. The clear sequencer zero-fills the whole array after reset and on demand. It is the next-generation replacement for the fixed 4096x60 single-port RAMs used as weight and activation buffers in the accelerator datapaths. Clients no longer need an external init pass, and they can update individual lanes of a wide word.

---
 rtl/spram_lanes_clr.sv | 147 ++++++++++++++
 tb/tb_spram_lanes_clr.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_lanes_clr.sv
// Single-port RAM with per-lane write enables, a valid/ready request port and a zero-fill clear sweep.
// Define SPRAM_LANES_CLR_OUT_REG_EN to add an output register stage (read latency 2 instead of 1).
module spram_lanes_clr #(
  parameter int AWIDTH     = 12,
  parameter int NUM_WORDS  = 4096,
  parameter int DWIDTH     = 60,
  parameter int LANE_WIDTH = 10,
  parameter int NUM_LANES  = DWIDTH / LANE_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  output logic                 busy,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 wren,
  input  logic [NUM_LANES-1:0] lane_en,
  input  logic [AWIDTH-1:0]    address,
  input  logic [DWIDTH-1:0]    data,
  output logic [DWIDTH-1:0]    out,
  output logic                 out_valid
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  state_t                state_reg, state_next;
  logic [AWIDTH-1:0]     counter_reg, counter_next;
  logic                  accept, wr_accept, rd_accept, in_range;
  logic [AWIDTH-1:0]     mem_addr;
  logic [NUM_LANES-1:0]  mem_we;
  logic [DWIDTH-1:0]     mem_wdata;
  logic                  mem_re;
  logic [DWIDTH-1:0]     rd_data;
  logic [DWIDTH-1:0]     rd_out;
  logic                  rd_valid_reg, rd_keep_reg;

  assign busy      = (state_reg == CLEAR);
  assign req_ready = (state_reg == READY) && !clear;
  assign accept    = req_valid && req_ready;
  assign wr_accept = accept && wren;
  assign rd_accept = accept && !wren;
  assign in_range  = (33'(address) < 33'(NUM_WORDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= CLEAR;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      CLEAR: begin
        if (counter_reg == LAST_ADDR) begin
          state_next   = READY;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + AWIDTH'(1);
        end
      end
      READY: begin
        if (clear) begin
          state_next   = CLEAR;
          counter_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // The single memory port is owned by the sweep while clearing, otherwise by the client.
  always_comb begin
    mem_addr  = address;
    mem_we    = '0;
    mem_wdata = data;
    mem_re    = 1'b0;
    if (state_reg == CLEAR) begin
      mem_addr  = counter_reg;
      mem_we    = '1;
      mem_wdata = '0;
    end else if (wr_accept && in_range) begin
      mem_we = lane_en;
    end else if (rd_accept && in_range) begin
      mem_re = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    logic [LANE_WIDTH-1:0] lane_mem [NUM_WORDS];
    logic [LANE_WIDTH-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (mem_we[gi]) begin
        lane_mem[mem_addr] <= mem_wdata[gi*LANE_WIDTH +: LANE_WIDTH];
      end
      if (mem_re) begin
        lane_q <= lane_mem[mem_addr];
      end
    end

    assign rd_data[gi*LANE_WIDTH +: LANE_WIDTH] = lane_q;
  end

  // rd_keep_reg masks the un-reset RAM output: zero after reset or after an out-of-range read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_keep_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_accept;
      if (rd_accept) begin
        rd_keep_reg <= in_range;
      end
    end
  end

  assign rd_out = rd_keep_reg ? rd_data : '0;

`ifdef SPRAM_LANES_CLR_OUT_REG_EN
  logic [DWIDTH-1:0] out_reg;
  logic              out_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_reg       <= rd_out;
      out_valid_reg <= rd_valid_reg;
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
`else
  assign out       = rd_out;
  assign out_valid = rd_valid_reg;
`endif

endmodule

// File: tb/tb_spram_lanes_clr.sv
// Randomized self-checking bench for spram_lanes_clr against a word-array reference model.
module tb_spram_lanes_clr;
  localparam int AW = 12;
  localparam int NW = 4096;
  localparam int DW = 60;
  localparam int LW = 10;
  localparam int NL = 6;
`ifdef SPRAM_LANES_CLR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          req_valid = 1'b0;
  logic          wren = 1'b0;
  logic [NL-1:0] lane_en = '0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data = '0;
  logic          busy, req_ready, out_valid;
  logic [DW-1:0] out;

  spram_lanes_clr dut (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .wren(wren),
    .lane_en(lane_en), .address(address), .data(data),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    bit            w;
    logic [NL-1:0] le;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            clr;
  } op_t;

  int n_checks = 0;
  int n_fail = 0;
  int tcount = 0;

  // reference model
  logic [DW-1:0] mem [NW];
  int            sweep_left;
  bit            pv [2];
  logic [DW-1:0] pd [2];
  logic [DW-1:0] exp_out;
  bit            exp_busy, exp_ready, exp_ov;
  logic          obs_busy, obs_ready, obs_ov;
  logic [DW-1:0] obs_out;

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) mem[i] = '0;
    sweep_left = NW;
    pv[0] = 1'b0; pv[1] = 1'b0;
    pd[0] = '0;   pd[1] = '0;
    exp_out = '0;
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [NL-1:0] le);
    logic [DW-1:0] m = '0;
    for (int i = 0; i < NL; i++)
      if (le[i]) m = m | (((DW'(1) << LW) - DW'(1)) << (i * LW));
    return m;
  endfunction

  // Drive one cycle of inputs at a negedge, advance the model at the posedge,
  // and capture observed/expected values for the caller to compare.
  task automatic tick(input bit v, input bit w, input logic [NL-1:0] le,
                      input logic [AW-1:0] a, input logic [DW-1:0] d, input bit clr);
    bit acc;
    logic [DW-1:0] m;
    req_valid = v; wren = w; lane_en = le; address = a; data = d; clear = clr;
    #1;
    obs_busy  = busy;
    obs_ready = req_ready;
    exp_busy  = (sweep_left > 0);
    exp_ready = !exp_busy && !clr;
    acc = v && exp_ready;
    @(posedge clk);
    if (sweep_left > 0) begin
      sweep_left--;
    end else if (clr) begin
      for (int i = 0; i < NW; i++) mem[i] = '0;
      sweep_left = NW;
    end else if (acc) begin
      if (w) begin
        m = lane_mask(le);
        mem[a] = (mem[a] & ~m) | (d & m);
      end else begin
        pv[LAT-1] = 1'b1;
        pd[LAT-1] = mem[a];
      end
    end
    if (v)
      $display("txn %0d: %s addr=%0d lane=%b data=%h clear=%0b accepted=%0b",
               tcount, w ? "WR" : "RD", a, le, d, clr, acc);
    tcount++;
    @(negedge clk);
    obs_ov  = out_valid;
    obs_out = out;
    exp_ov  = pv[0];
    if (pv[0]) exp_out = pd[0];
    pv[0] = pv[1]; pd[0] = pd[1];
    pv[1] = 1'b0;
  endtask

  task automatic run_sweep(output int n_busy, output int n_bad);
    n_busy = 0;
    n_bad = 0;
    for (int i = 0; i < NW + 200; i++) begin
      tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) n_bad++;
      if (!obs_busy) break;
      n_busy++;
    end
  endtask

  task automatic test_reset();
    op_t ops[$];
    int nb, nbad;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({busy, req_ready, out_valid, out} !== {1'b1, 1'b0, 1'b0, DW'(0)}) begin
        n_fail++;
        $display("FAIL reset_hold: busy,ready,ov,out=%b,%b,%b,%h required 1,0,0,0", busy, req_ready, out_valid, out);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    run_sweep(nb, nbad);
    n_checks++;
    if (nb !== NW) begin
      n_fail++;
      $display("FAIL reset_sweep_len: busy cycles %0d required %0d", nb, NW);
    end
    n_checks++;
    if (nbad !== 0) begin
      n_fail++;
      $display("FAIL reset_sweep_cycles: %0d mismatching cycles required 0", nbad);
    end
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: req_ready %b required 1", obs_ready);
    end
    ops.push_back('{1, 0, 6'd0, 12'd0, 60'd0, 0});
    ops.push_back('{1, 0, 6'd0, 12'd2047, 60'd0, 0});
    ops.push_back('{1, 0, 6'd0, 12'd4095, 60'd0, 0});
    for (int i = 0; i < LAT; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    foreach (ops[i]) begin
      tick(ops[i].v, ops[i].w, ops[i].le, ops[i].a, ops[i].d, ops[i].clr);
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        $display("FAIL reset_reads step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                 i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
      end
    end
  endtask

  task automatic test_lane_write();
    op_t ops[$];
    logic [DW-1:0] last_rd;
    last_rd = '1;
    ops.push_back('{1, 1, 6'b111111, 12'd5, 60'h0FF_FFFF_FFFF_FFFF, 0});
    ops.push_back('{1, 1, 6'b000010, 12'd5, 60'd0, 0});
    ops.push_back('{1, 1, 6'b000000, 12'd5, 60'd0, 0});
    ops.push_back('{1, 0, 6'd0, 12'd5, 60'd0, 0});
    for (int i = 0; i < LAT; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    foreach (ops[i]) begin
      tick(ops[i].v, ops[i].w, ops[i].le, ops[i].a, ops[i].d, ops[i].clr);
      if (obs_ov) last_rd = obs_out;
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        $display("FAIL lane_write step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                 i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
      end
    end
    n_checks++;
    if (last_rd !== 60'h0FF_FFFF_FFF0_03FF) begin
      n_fail++;
      $display("FAIL lane_merge: read %h required %h", last_rd, 60'h0FF_FFFF_FFF0_03FF);
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    logic [DW-1:0] got[$];
    int first_idx, last_idx;
    first_idx = -1;
    last_idx = -1;
    ops.push_back('{1, 1, 6'b111111, 12'd1, 60'd11, 0});
    ops.push_back('{1, 1, 6'b111111, 12'd2, 60'd22, 0});
    ops.push_back('{1, 1, 6'b111111, 12'd3, 60'd33, 0});
    ops.push_back('{1, 0, 6'd0, 12'd1, 60'd0, 0});
    ops.push_back('{1, 0, 6'd0, 12'd2, 60'd0, 0});
    ops.push_back('{1, 0, 6'd0, 12'd3, 60'd0, 0});
    for (int i = 0; i < LAT + 1; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    foreach (ops[i]) begin
      tick(ops[i].v, ops[i].w, ops[i].le, ops[i].a, ops[i].d, ops[i].clr);
      if (obs_ov) begin
        got.push_back(obs_out);
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        $display("FAIL b2b step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                 i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
      end
    end
    n_checks++;
    if (got.size() !== 3 || first_idx !== 3 + LAT - 1 || last_idx !== 5 + LAT - 1) begin
      n_fail++;
      $display("FAIL b2b_timing: %0d results in steps %0d..%0d required 3 in steps %0d..%0d",
               got.size(), first_idx, last_idx, 3 + LAT - 1, 5 + LAT - 1);
    end else begin
      n_checks++;
      if (got[0] !== DW'(11) || got[1] !== DW'(22) || got[2] !== DW'(33)) begin
        n_fail++;
        $display("FAIL b2b_data: %0d,%0d,%0d required 11,22,33", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_random();
    int bad_prints = 0;
    logic [AW-1:0] a;
    for (int i = 0; i < 300 + LAT; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      if (i < 300)
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NL'($urandom),
             a, DW'({$urandom(), $urandom()}), 1'b0);
      else
        tick(1'b0, 1'b0, '0, '0, '0, 1'b0);
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        if (bad_prints < 10)
          $display("FAIL random step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                   i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
        bad_prints++;
      end
    end
  endtask

  task automatic test_clear_collision();
    op_t ops[$];
    int nb, nbad;
    logic [DW-1:0] last_rd;
    last_rd = '1;
    tick(1'b1, 1'b1, 6'b111111, 12'd7, 60'd55, 1'b0);
    tick(1'b1, 1'b0, 6'd0, 12'd7, 60'd0, 1'b0);
    n_checks++;
    if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
      n_fail++;
      $display("FAIL collide_pre: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
               obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
    end
    tick(1'b1, 1'b1, 6'b111111, 12'd7, 60'd99, 1'b1);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_ready: req_ready %b required 0", obs_ready);
    end
    n_checks++;
    if ({obs_busy, obs_ov, obs_out} !== {exp_busy, exp_ov, exp_out}) begin
      n_fail++;
      $display("FAIL collide_cycle: busy,ov,out=%b,%b,%h required %b,%b,%h",
               obs_busy, obs_ov, obs_out, exp_busy, exp_ov, exp_out);
    end
    run_sweep(nb, nbad);
    n_checks++;
    if (nb !== NW || nbad !== 0) begin
      n_fail++;
      $display("FAIL collide_sweep: busy cycles %0d, bad cycles %0d required %0d, 0", nb, nbad, NW);
    end
    ops.push_back('{1, 0, 6'd0, 12'd7, 60'd0, 0});
    for (int i = 0; i < LAT; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    foreach (ops[i]) begin
      tick(ops[i].v, ops[i].w, ops[i].le, ops[i].a, ops[i].d, ops[i].clr);
      if (obs_ov) last_rd = obs_out;
    end
    n_checks++;
    if (last_rd !== DW'(0)) begin
      n_fail++;
      $display("FAIL collide_addr7: read %h required 0", last_rd);
    end
  endtask

  task automatic test_reset_mid_sweep();
    op_t ops[$];
    int nb, nbad;
    ops.push_back('{1, 1, 6'b111111, 12'd20, 60'd123, 0});
    ops.push_back('{1, 0, 6'd0, 12'd20, 60'd0, 0});
    for (int i = 0; i < LAT; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 1});
    for (int i = 0; i < 100; i++) ops.push_back('{0, 0, 6'd0, 12'd0, 60'd0, 0});
    foreach (ops[i]) begin
      tick(ops[i].v, ops[i].w, ops[i].le, ops[i].a, ops[i].d, ops[i].clr);
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        $display("FAIL midreset_pre step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                 i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
      end
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({busy, req_ready, out_valid, out} !== {1'b1, 1'b0, 1'b0, DW'(0)}) begin
        n_fail++;
        $display("FAIL midreset_hold %0d: busy,ready,ov,out=%b,%b,%b,%h required 1,0,0,0",
                 i, busy, req_ready, out_valid, out);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    run_sweep(nb, nbad);
    n_checks++;
    if (nb !== NW || nbad !== 0) begin
      n_fail++;
      $display("FAIL midreset_sweep: busy cycles %0d, bad cycles %0d required %0d, 0", nb, nbad, NW);
    end
  endtask

  task automatic test_clear_ignored();
    int nb, nbad, busy_cnt;
    busy_cnt = 0;
    tick(1'b0, 1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 501; i++) begin
      tick(1'b0, 1'b0, '0, '0, '0, i == 500);
      if (obs_busy) busy_cnt++;
      n_checks++;
      if ({obs_busy, obs_ready, obs_ov, obs_out} !== {exp_busy, exp_ready, exp_ov, exp_out}) begin
        n_fail++;
        $display("FAIL clear_busy step %0d: busy,ready,ov,out=%b,%b,%b,%h required %b,%b,%b,%h",
                 i, obs_busy, obs_ready, obs_ov, obs_out, exp_busy, exp_ready, exp_ov, exp_out);
      end
    end
    run_sweep(nb, nbad);
    n_checks++;
    if (busy_cnt + nb !== NW || nbad !== 0) begin
      n_fail++;
      $display("FAIL clear_ignored: busy cycles %0d, bad cycles %0d required %0d, 0", busy_cnt + nb, nbad, NW);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lane_write();
    test_back_to_back();
    test_random();
    test_clear_collision();
    test_reset_mid_sweep();
    test_clear_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
